hazard_sched: RTL and testbench

- Pipeline hazard and issue scheduler for the 16-bit pipelined core.
- Sits between fetch/decode and the control pipeline (stages A→B→C); decides each cycle whether the decoded instruction issues, stalls, or is squashed.
- Tracks in-flight destinations in stages B and C and sequences the multi-cycle multiplier (opcode 15).
- Raises flush on jumps and taken branches, and keeps a stall performance counter.

---
 rtl/hazard_sched.sv | 141 ++++++++++++++
 tb/tb_hazard_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Issue/stall/squash scheduler for the A->B->C control pipeline: tracks the
// destinations held in stages B and C, sequences the multi-cycle MUL and counts stalls.
module hazard_sched #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_inst,
    input  logic             id_valid,
    input  logic             br_taken,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int              MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LAT - 1);
    localparam logic [3:0]      OP_J     = 4'd11;
    localparam logic [3:0]      OP_BR    = 4'd12;
    localparam logic [3:0]      OP_MUL   = 4'd15;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [3:0] rd;
        logic       is_mul;
        logic       is_br;
    } tag_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic en, input logic [3:0] src, input tag_t t);
        return en && t.valid && t.wr && (t.rd != 4'd0) && (src == t.rd);
    endfunction

    tag_t              b_q, b_d, c_q, c_d, id_tag;
    logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [3:0] id_op, id_rd, id_rs, id_rt, src_a, src_b;
    logic       id_is_j, id_is_br, id_is_mul, id_is_i;
    logic       src_a_en, src_b_en;
    logic       busy, br_squash, raw_hit;
    logic       unused_c_flags;

    assign id_op     = id_inst[15:12];
    assign id_rd     = id_inst[11:8];
    assign id_rs     = id_inst[7:4];
    assign id_rt     = id_inst[3:0];
    assign id_is_j   = (id_op == OP_J);
    assign id_is_br  = (id_op == OP_BR);
    assign id_is_mul = (id_op == OP_MUL);
    assign id_is_i   = id_op inside {4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

    // Branches read rd/rs in the slots where other classes read rs/rt.
    assign src_a    = id_is_br ? id_rd : id_rs;
    assign src_b    = id_is_br ? id_rs : id_rt;
    assign src_a_en = !id_is_j;
    assign src_b_en = !(id_is_j || id_is_i);

    assign id_tag = '{valid:  1'b1,
                      wr:     !(id_is_j || id_is_br),
                      rd:     id_rd,
                      is_mul: id_is_mul,
                      is_br:  id_is_br};

    assign busy      = b_q.is_mul && (mul_cnt_q != '0);
    assign br_squash = b_q.valid && b_q.is_br && br_taken;
    assign raw_hit   = id_valid && (reg_hit(src_a_en, src_a, b_q) || reg_hit(src_b_en, src_b, b_q));

    assign unused_c_flags = c_q.is_mul ^ c_q.is_br;
    assign stall_cnt      = stall_cnt_q;

    always_comb begin
        issue    = 1'b0;
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        fwd_a    = 1'b0;
        fwd_b    = 1'b0;
        mul_busy = 1'b0;
        if (!rst) begin
            mul_busy = busy;
            if (busy) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else if (br_squash) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (raw_hit) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else if (id_valid) begin
                issue = 1'b1;
                flush = id_is_j;
                fwd_a = reg_hit(src_a_en, src_a, c_q);
                fwd_b = reg_hit(src_b_en, src_b, c_q);
            end
        end
    end

    always_comb begin
        b_d       = b_q;
        c_d       = c_q;
        mul_cnt_d = mul_cnt_q;
        if (busy) begin
            c_d       = '0;
            mul_cnt_d = mul_cnt_q - MC_W'(1);
        end else begin
            c_d = b_q;
            b_d = issue ? id_tag : '0;
            if (issue && id_is_mul) begin
                mul_cnt_d = MUL_LOAD;
            end
        end
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // B/C tag stage boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q         <= '0;
            c_q         <= '0;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            b_q         <= b_d;
            c_q         <= c_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_sched.sv
// Randomized bench for hazard_sched: an operand-list / occupancy-age model predicts
// every output each cycle, with directed scenarios pinning hand-computed values.
module tb_hazard_sched;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      id_inst = 16'h0;
    logic             id_valid = 1'b0;
    logic             br_taken = 1'b0;
    logic             issue, stall, bubble, flush, fwd_a, fwd_b, mul_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_sched #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .br_taken(br_taken),
        .issue(issue), .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { bit v; bit wr; bit [3:0] rd; bit br; bit mul; } ent_t;
    typedef struct packed { bit issue; bit stall; bit bubble; bit flush; bit fwd_a; bit fwd_b; bit busy; } exp_t;

    ent_t mb, mc;          // what sits in stage B / stage C
    int   mul_age;         // cycles the instruction in B has spent there
    int   m_stalls;
    logic m_busy;
    exp_t e_now;

    // k-th register operand the instruction reads, -1 when that slot is unused
    function automatic int opnd(input logic [15:0] i, input int k);
        int op;
        op = int'(i[15:12]);
        if (op inside {0, 1, 3, 4, 5, 13, 14, 15}) return (k == 0) ? int'(i[7:4]) : int'(i[3:0]);
        if (op inside {2, 6, 7, 8, 9, 10})         return (k == 0) ? int'(i[7:4]) : -1;
        if (op == 12)                              return (k == 0) ? int'(i[11:8]) : int'(i[7:4]);
        return -1;
    endfunction

    function automatic bit depends(input logic [15:0] i, input ent_t s, input int k);
        return s.v && s.wr && (s.rd != 0) && (opnd(i, k) == int'(s.rd));
    endfunction

    function automatic ent_t decode(input logic [15:0] i);
        ent_t e;
        e.v   = 1'b1;
        e.wr  = !(i[15:12] inside {4'd11, 4'd12});
        e.rd  = i[11:8];
        e.br  = (i[15:12] == 4'd12);
        e.mul = (i[15:12] == 4'd15);
        return e;
    endfunction

    always_comb m_busy = !rst && mb.v && mb.mul && (mul_age < MUL_LAT);

    always_comb begin
        e_now = '0;
        if (!rst) begin
            e_now.busy = m_busy;
            if (m_busy) begin
                e_now.stall  = 1'b1;
                e_now.bubble = 1'b1;
            end else if (mb.v && mb.br && br_taken) begin
                e_now.flush  = 1'b1;
                e_now.bubble = 1'b1;
            end else if (id_valid && (depends(id_inst, mb, 0) || depends(id_inst, mb, 1))) begin
                e_now.stall  = 1'b1;
                e_now.bubble = 1'b1;
            end else if (id_valid) begin
                e_now.issue = 1'b1;
                e_now.flush = (id_inst[15:12] == 4'd11);
                e_now.fwd_a = depends(id_inst, mc, 0);
                e_now.fwd_b = depends(id_inst, mc, 1);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb       <= '0;
            mc       <= '0;
            mul_age  <= 0;
            m_stalls <= 0;
        end else begin
            if (e_now.stall && m_stalls < SAT) m_stalls <= m_stalls + 1;
            if (m_busy) begin
                mc      <= '0;
                mul_age <= mul_age + 1;
            end else begin
                mc      <= mb;
                mb      <= e_now.issue ? decode(id_inst) : '0;
                mul_age <= 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("issue",     int'(issue),     int'(e_now.issue));
            chk("stall",     int'(stall),     int'(e_now.stall));
            chk("bubble",    int'(bubble),    int'(e_now.bubble));
            chk("flush",     int'(flush),     int'(e_now.flush));
            chk("fwd_a",     int'(fwd_a),     int'(e_now.fwd_a));
            chk("fwd_b",     int'(fwd_b),     int'(e_now.fwd_b));
            chk("mul_busy",  int'(mul_busy),  int'(e_now.busy));
            chk("stall_cnt", int'(stall_cnt), m_stalls);
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] inst, input logic v, input logic bt);
        id_inst  = inst;
        id_valid = v;
        br_taken = bt;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        id_valid = 1'b0;
        br_taken = 1'b0;
        id_inst  = 16'h0;
        next_cyc();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [15:0] r;
        r[15:12] = 4'($urandom_range(0, 15));
        r[11:8]  = 4'($urandom_range(0, 3));
        r[7:4]   = 4'($urandom_range(0, 3));
        r[3:0]   = 4'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        rst      = 1'b1;
        id_inst  = 16'h1123;
        id_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_issue",     int'(issue),     0);
        chk("rst_stall",     int'(stall),     0);
        chk("rst_flush",     int'(flush),     0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk_en = 1'b1;
        next_cyc();
        rst = 1'b0;

        // RAW on r1 against B, then forwarded from C
        do_reset();
        put(16'h1123, 1, 0);
        chk("t1_first_issue", int'(issue), 1);
        next_cyc();
        put(16'h0415, 1, 0);
        chk("t1_stall",  int'(stall),  1);
        chk("t1_bubble", int'(bubble), 1);
        chk("t1_issue0", int'(issue),  0);
        chk("t1_model_stall", int'(e_now.stall), 1);
        next_cyc();
        put(16'h0415, 1, 0);
        chk("t1_issue", int'(issue), 1);
        chk("t1_fwd_a", int'(fwd_a), 1);
        chk("t1_fwd_b", int'(fwd_b), 0);
        chk("t1_cnt",   int'(stall_cnt), 1);
        chk("t1_model_fwd_a", int'(e_now.fwd_a), 1);

        // r0 is not a dependency
        do_reset();
        put(16'h1123, 1, 0);
        next_cyc();
        put(16'h2000, 1, 0);
        chk("t2_stall", int'(stall), 0);
        chk("t2_issue", int'(issue), 1);
        chk("t2_fwd_a", int'(fwd_a), 0);

        // MUL occupies B for MUL_LAT cycles
        do_reset();
        put(16'hF523, 1, 0);
        chk("t3_mul_issue", int'(issue), 1);
        chk("t3_busy0",     int'(mul_busy), 0);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t3_busy1",  int'(mul_busy), 1);
        chk("t3_stall1", int'(stall),    1);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t3_busy2",  int'(mul_busy), 1);
        chk("t3_stall2", int'(stall),    1);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t3_busy3",  int'(mul_busy), 0);
        chk("t3_issue",  int'(issue),    1);
        chk("t3_cnt",    int'(stall_cnt), 2);
        chk("t3_model_cnt", m_stalls, 2);

        // taken branch in B squashes the id instruction
        do_reset();
        put(16'hC120, 1, 0);
        chk("t4_br_issue", int'(issue), 1);
        next_cyc();
        put(16'h1789, 1, 1);
        chk("t4_flush",  int'(flush),  1);
        chk("t4_issue0", int'(issue),  0);
        chk("t4_bubble", int'(bubble), 1);
        chk("t4_stall",  int'(stall),  0);
        next_cyc();
        put(16'h1021, 1, 1);
        chk("t4_noflush", int'(flush), 0);
        chk("t4_issue",   int'(issue), 1);
        chk("t4_fwd_b",   int'(fwd_b), 0);

        // jump issues and flushes in the same cycle
        do_reset();
        put(16'hB005, 1, 0);
        chk("t5_issue", int'(issue), 1);
        chk("t5_flush", int'(flush), 1);
        chk("t5_stall", int'(stall), 0);

        // asynchronous reset in the middle of a MUL
        do_reset();
        put(16'hF523, 1, 0);
        next_cyc();
        put(16'h1634, 1, 0);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t6_busy_pre", int'(mul_busy), 1);
        chk("t6_cnt_pre",  int'(stall_cnt), 1);
        rst = 1'b1;
        #1;
        chk("t6_busy",  int'(mul_busy), 0);
        chk("t6_issue", int'(issue),    0);
        chk("t6_stall", int'(stall),    0);
        chk("t6_cnt",   int'(stall_cnt), 0);
        next_cyc();
        rst = 1'b0;
        put(16'hF523, 1, 0);
        chk("t6_mul_issue", int'(issue), 1);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t6_busy1", int'(mul_busy), 1);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t6_busy2", int'(mul_busy), 1);
        next_cyc();
        put(16'h1634, 1, 0);
        chk("t6_busy3",  int'(mul_busy), 0);
        chk("t6_issue3", int'(issue),    1);

        // random traffic, occasional asynchronous reset pulses
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                next_cyc();
                rst = 1'b0;
            end else begin
                put(rand_inst(), ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
                next_cyc();
            end
        end

        // back-to-back MULs drive the stall counter into saturation
        do_reset();
        put(16'hF523, 1, 0);
        for (int i = 0; i < 30; i++) next_cyc();
        #1;
        chk("sat_cnt", int'(stall_cnt), SAT);

        id_valid = 1'b0;
        next_cyc();
        next_cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
